// File: rtl/dm_lsu_if.sv
// ---------------------------------------------------------------------------
// dm_lsu_if
// CPU-side request/response bundle of the load/store unit.
//   req_valid/req_ready  request handshake (accept = valid & ready)
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_sign             sign-extend (1) / zero-extend (0) loads
//   req_addr             byte address, ADDR_WIDTH+2 bits
//   req_wdata            store data, right-aligned in lane 0
//   resp_valid           one-cycle response pulse, no backpressure
//   resp_rdata           extended load data, 0 for stores and errors
//   resp_err             request was misaligned or illegal
// Modports: master = CPU (drives the request), slave = LSU (drives ready and
// the response).
// ---------------------------------------------------------------------------
interface dm_lsu_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_sign;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_lsu.sv
// ---------------------------------------------------------------------------
// dm_lsu
// Load/store unit on the requester side of a word-addressed data memory.
// Accepts one byte-addressed CPU request at a time, performs word loads with
// lane extraction and sign/zero extension, word stores directly, and byte /
// halfword stores as a read-modify-write of the containing word.
// Ports:
//   clk, rst     rising-edge clock shared with the DM; synchronous active-high
//                reset
//   cpu          dm_lsu_if.slave request/response bundle
//   dm_R, dm_W   DM read / write enables (forced low while rst is high)
//   dm_Addr      DM word address = latched byte address [ADDR_WIDTH+1:2]
//   dm_W_data    DM write data
//   dm_R_data    DM read data, valid the cycle after dm_R
// ---------------------------------------------------------------------------
module dm_lsu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dm_lsu_if.slave               cpu,
  output logic                  dm_R,
  output logic                  dm_W,
  output logic [ADDR_WIDTH-1:0] dm_Addr,
  output logic [DATA_WIDTH-1:0] dm_W_data,
  input  logic [DATA_WIDTH-1:0] dm_R_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LDFMT,
    S_WRM,
    S_WR,
    S_ERR
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  misaligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_ext;
  logic [31:0]           rmw_data;

  // Illegal size, or a half/word not on its natural boundary, never reaches
  // the DM.
  always_comb begin
    misaligned = 1'b0;
    case (cpu.req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = cpu.req_addr[0];
      SZ_WORD: misaligned = (cpu.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Little-endian lane extraction from the word returned by the DM.
  always_comb begin
    ld_byte = dm_R_data[7:0];
    case (addr_q[1:0])
      2'd0:    ld_byte = dm_R_data[7:0];
      2'd1:    ld_byte = dm_R_data[15:8];
      2'd2:    ld_byte = dm_R_data[23:16];
      default: ld_byte = dm_R_data[31:24];
    endcase
    ld_half = addr_q[1] ? dm_R_data[31:16] : dm_R_data[15:0];
    ld_ext  = dm_R_data;
    case (size_q)
      SZ_BYTE: ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
      default: ld_ext = dm_R_data;
    endcase
  end

  // Merge the store lane(s) into the word just read; untouched lanes pass
  // through so the RMW leaves the rest of the word intact.
  always_comb begin
    rmw_data = dm_R_data;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    rmw_data[7:0]   = wdata_q[7:0];
        2'd1:    rmw_data[15:8]  = wdata_q[7:0];
        2'd2:    rmw_data[23:16] = wdata_q[7:0];
        default: rmw_data[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      rmw_data[31:16] = wdata_q[15:0];
    end else begin
      rmw_data[15:0]  = wdata_q[15:0];
    end
  end

  // Next-state and response computation. Request fields are latched only on
  // accept, so dm_Addr stays fixed across RD and WRM.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (cpu.req_valid) begin
          we_d    = cpu.req_we;
          size_d  = cpu.req_size;
          sign_d  = cpu.req_sign;
          addr_d  = cpu.req_addr;
          wdata_d = cpu.req_wdata;
          if (misaligned)
            state_d = S_ERR;
          else if (cpu.req_we && (cpu.req_size == SZ_WORD))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = we_q ? S_WRM : S_LDFMT;
      end
      S_LDFMT: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_ext;
        resp_err_d   = 1'b0;
        state_d      = S_IDLE;
      end
      S_WRM, S_WR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        state_d      = S_IDLE;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Enables are gated by rst so an aborted RMW cannot write in the reset cycle.
  assign dm_R      = (state_q == S_RD) && !rst;
  assign dm_W      = ((state_q == S_WRM) || (state_q == S_WR)) && !rst;
  assign dm_Addr   = addr_q[ADDR_WIDTH+1:2];
  assign dm_W_data = (state_q == S_WR) ? wdata_q : rmw_data;

  assign cpu.req_ready  = (state_q == S_IDLE);
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_rdata = resp_rdata_q;
  assign cpu.resp_err   = resp_err_q;

endmodule
